hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_MULT_CYCLES, default 4, the front-end stall length in cycles for a multiply.
REQ-002 The block SHALL have parameter MD_DIV_CYCLES, default 32, the front-end stall length in cycles for a divide.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 ex_mem_read  input  1  the instruction in EX is a load.
REQ-007 ex_rt  input  5  destination register of the load in EX.
REQ-008 branch_taken  input  1  branch or jump resolved taken in ID this cycle.
REQ-009 md_start  input  1  a mult/div enters EX this cycle.
REQ-010 md_is_div  input  1  qualifies md_start: 1 = divide, 0 = multiply.
REQ-011 pc_write  output  1  PC load enable.
REQ-012 if_id_write  output  1  IF/ID write enable; 0 = hold contents.
REQ-013 if_id_flush  output  1  IF/ID flush: zero the instruction.
REQ-014 id_ex_write  output  1  ID/EX write enable; 0 = hold contents.
REQ-015 id_ex_flush  output  1  ID/EX flush: insert a bubble.
REQ-016 md_busy  output  1  mult/div stall is in progress.
REQ-017 md_done  output  1  one-cycle pulse on the last stall cycle.

Function
REQ-018 All control outputs SHALL be combinational from the current state and inputs; only the FSM state and the counter SHALL be registered.
REQ-019 Load-use condition: ex_mem_read=1, ex_rt!=0, and ex_rt equals id_rs or id_rt.
REQ-020 Load-use response, same cycle: pc_write=0, if_id_write=0, id_ex_flush=1; exactly one bubble per hazard.
REQ-021 Taken-branch response, no other hazard active: if_id_flush=1, pc_write=1, if_id_write=1.
REQ-022 Register 0 SHALL never create a hazard.
REQ-023 FSM states: IDLE and MD_BUSY.
REQ-024 Transition IDLE to MD_BUSY: on md_start=1; the counter loads N-1.
REQ-025 N is MD_DIV_CYCLES when md_is_div=1, else MD_MULT_CYCLES.
REQ-026 MD_BUSY: the counter decrements each cycle; when it equals 1, md_done=1 and the next state is IDLE.
REQ-027 MD stall condition: (IDLE and md_start) or MD_BUSY.
REQ-028 MD stall response: pc_write=0, if_id_write=0, id_ex_write=0, no flushes, md_busy=1.
REQ-029 The MD stall SHALL last exactly N cycles; freeze is released on cycle N+1.
REQ-030 Priority: MD stall, then load-use, then taken branch.
REQ-031 A lower-priority event coinciding with a higher one SHALL be ignored that cycle; the ID stage re-presents it.
REQ-032 md_start while MD_BUSY SHALL be ignored; the counter is not reloaded.
REQ-033 Idle outputs: pc_write=1, if_id_write=1, id_ex_write=1; all other outputs 0.

Reset
REQ-034 reset=0 at a posedge SHALL force state IDLE and counter 0, including mid-MD_BUSY.
REQ-035 While reset=0, outputs SHALL equal the idle values regardless of other inputs.
REQ-036 No md_done pulse SHALL be produced for an operation aborted by reset.

Configuration
REQ-037 Macro HAZARD_CTRL_MD_EN defined: MD stall logic (REQ-023 to REQ-032) is present.
REQ-038 Macro HAZARD_CTRL_MD_EN undefined: md_start and md_is_div are ignored; md_busy=0, md_done=0, id_ex_write=1 constant; no counter is synthesised.

Structure
REQ-039 Shared package hazard_pkg SHALL hold the FSM state encoding, REG_ZERO=5'd0, and the default MD cycle counts.
REQ-040 Sub-module md_stall_counter SHALL hold the FSM and the 6-bit down-counter.
REQ-041 md_stall_counter SHALL expose start, is_div, busy and done; hazard_ctrl holds the hazard comparators and priority mux.

Verification
REQ-042 ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle idle values.
REQ-043 ex_mem_read=1, ex_rt=0, id_rt=0 -> no stall; idle values.
REQ-044 md_start=1, md_is_div=0 -> md_busy=1 and pc_write=0 for exactly 4 cycles; md_done on the 4th; pc_write=1 on the 5th.
REQ-045 md_start=1, md_is_div=1 -> 32-cycle freeze; a second md_start on stall cycle 10 does not extend it.
REQ-046 branch_taken=1 together with load-use -> only the load-use response, if_id_flush=0; branch_taken alone next cycle -> if_id_flush=1.
REQ-047 reset=0 on divide stall cycle 5 -> next cycle IDLE with idle values and no md_done pulse.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and its mult/div stall counter.
// Used by hazard_ctrl; MD stall logic is enabled with macro HAZARD_CTRL_MD_EN.
package hazard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MD_CNT_W            = 6;
  localparam int unsigned MD_MULT_CYCLES_DEF  = 4;
  localparam int unsigned MD_DIV_CYCLES_DEF   = 32;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_stall_counter.sv
// Mult/div front-end stall sequencer: IDLE/MD_BUSY FSM with a 6-bit down-counter.
// Only instantiated when HAZARD_CTRL_MD_EN is defined.
module md_stall_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [MD_CNT_W-1:0]   load;

  assign load = is_div ? DIV_LOAD : MULT_LOAD;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle is itself the first stall cycle, hence the N-1 load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start && (load != '0)) begin
          state_d = MD_BUSY;
          cnt_d   = load;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        busy = start;
        done = start && (load == '0);
      end
      MD_BUSY: begin
        busy = 1'b1;
        done = (cnt_q == CNT_ONE);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and mult/div freeze.
// The mult/div freeze is present only when HAZARD_CTRL_MD_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned MD_DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       branch_taken,
  input  logic       md_start,
  input  logic       md_is_div,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_write,
  output logic       id_ex_flush,
  output logic       md_busy,
  output logic       md_done
);

  logic load_use;
  logic md_stall;
  logic md_last;

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

`ifdef HAZARD_CTRL_MD_EN
  md_stall_counter #(
    .MULT_CYCLES (MD_MULT_CYCLES),
    .DIV_CYCLES  (MD_DIV_CYCLES)
  ) u_md_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_is_div),
    .busy   (md_stall),
    .done   (md_last)
  );
`else
  logic unused_md;
  assign unused_md = ^{clk, md_start, md_is_div};
  assign md_stall  = 1'b0;
  assign md_last   = 1'b0;
`endif

  // Priority: MD freeze > load-use bubble > taken-branch flush; reset forces idle.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_write = 1'b1;
    id_ex_flush = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    if (!reset) begin
      // hold idle values
    end else if (md_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      md_busy     = 1'b1;
      md_done     = md_last;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; MD freeze vectors run when
// HAZARD_CTRL_MD_EN is defined, otherwise the disabled-feature behaviour is checked.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, branch_taken, md_start, md_is_div;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic       md_busy, md_done;
  logic [6:0] obs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, md_busy, md_done}
  localparam logic [6:0] O_IDLE = 7'b1101000;
  localparam logic [6:0] O_LU   = 7'b0001100;
  localparam logic [6:0] O_BR   = 7'b1111000;
  localparam logic [6:0] O_MD   = 7'b0000010;
  localparam logic [6:0] O_MDD  = 7'b0000011;

  always #5 clk = ~clk;

  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, md_busy, md_done};

  hazard_ctrl #(
    .MD_MULT_CYCLES (4),
    .MD_DIV_CYCLES  (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_flush  (id_ex_flush),
    .md_busy      (md_busy),
    .md_done      (md_done)
  );

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs are set just after a posedge; outputs are checked at the following negedge.
  task automatic step(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check_eq(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; branch_taken = 1'b0;
    md_start = 1'b0; md_is_div = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert);
    id_rs = rs; id_rt = rt; ex_rt = ert; ex_mem_read = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clr();
    // Reset held with every hazard source active: idle values regardless
    set_lu(5'd8, 5'd3, 5'd8);
    branch_taken = 1'b1; md_start = 1'b1; md_is_div = 1'b1;
    @(posedge clk); #1;
    step("rst_noisy0", O_IDLE);
    step("rst_noisy1", O_IDLE);
    reset = 1'b1;
    clr();
    step("idle_after_rst", O_IDLE);

    // Load-use on rs, one bubble, then idle
    set_lu(5'd8, 5'd0, 5'd8);
    step("lu_rs", O_LU);
    clr();
    step("lu_rs_next", O_IDLE);
    set_lu(5'd1, 5'd9, 5'd9);
    step("lu_rt", O_LU);
    set_lu(5'd9, 5'd9, 5'd9);
    ex_mem_read = 1'b0;
    step("no_load", O_IDLE);
    set_lu(5'd0, 5'd0, 5'd0);
    step("reg0_rt", O_IDLE);
    set_lu(5'd4, 5'd5, 5'd6);
    step("lu_mismatch", O_IDLE);
    set_lu(5'd31, 5'd2, 5'd31);
    step("lu_r31", O_LU);
    clr();

    // Taken branch alone, then coinciding with load-use
    branch_taken = 1'b1;
    step("br_alone", O_BR);
    set_lu(5'd8, 5'd0, 5'd8);
    step("br_with_lu", O_LU);
    clr();
    branch_taken = 1'b1;
    step("br_represent", O_BR);
    clr();
    step("idle_pre_md", O_IDLE);

`ifdef HAZARD_CTRL_MD_EN
    // Multiply: 4-cycle freeze; lower-priority events during it are masked
    md_start = 1'b1; md_is_div = 1'b0;
    step("mul_c1", O_MD);
    clr();
    set_lu(5'd8, 5'd0, 5'd8);
    branch_taken = 1'b1;
    step("mul_c2_masked", O_MD);
    clr();
    step("mul_c3", O_MD);
    step("mul_c4_done", O_MDD);
    step("mul_c5_release", O_IDLE);

    // Divide: 32-cycle freeze; a second start on cycle 10 is ignored
    md_start = 1'b1; md_is_div = 1'b1;
    step("div_c1", O_MD);
    clr();
    for (int unsigned c = 2; c <= 31; c++) begin
      md_start = (c == 10);
      step($sformatf("div_c%0d", c), O_MD);
    end
    clr();
    step("div_c32_done", O_MDD);
    step("div_c33_release", O_IDLE);

    // Divide aborted by reset on stall cycle 5: no done pulse afterwards
    md_start = 1'b1; md_is_div = 1'b1;
    step("abort_c1", O_MD);
    clr();
    for (int unsigned c = 2; c <= 4; c++) step($sformatf("abort_c%0d", c), O_MD);
    reset = 1'b0;
    step("abort_c5_rst", O_IDLE);
    reset = 1'b1;
    for (int unsigned c = 6; c <= 40; c++) step($sformatf("abort_post_c%0d", c), O_IDLE);

    // Fresh multiply after the abort starts normally
    md_start = 1'b1;
    step("remul_c1", O_MD);
    clr();
    step("remul_c2", O_MD);
    step("remul_c3", O_MD);
    step("remul_c4_done", O_MDD);
    step("remul_c5", O_IDLE);
`else
    // Feature absent: md_start/md_is_div have no effect
    md_start = 1'b1; md_is_div = 1'b1;
    for (int unsigned c = 1; c <= 6; c++) step($sformatf("nomd_div_c%0d", c), O_IDLE);
    md_is_div = 1'b0;
    step("nomd_mul", O_IDLE);
    set_lu(5'd8, 5'd0, 5'd8);
    step("nomd_lu", O_LU);
    clr();
    branch_taken = 1'b1; md_start = 1'b1;
    step("nomd_br", O_BR);
    clr();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
